// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types for the sequence-detector sequencing controller.
// Holds the controller state encoding and the default word width.
package seq_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Word-in / result-out handshake bundle for the detector controller.
// The master side produces words and consumes results.
interface seq_detect_ctrl_if
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic [WIDTH-1:0] res_mask;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_count, res_mask
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_count, res_mask
  );

endinterface

// File: rtl/seq_detect_top.sv
// Pairs the sequencing controller with one serial detector instance.
// Word and result traffic arrive over the handshake interface.
module seq_detect_top
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  seq_detect_ctrl_if.slave  bus
);

  logic w_det_rst;
  logic w_det_x;
  logic w_det_y;

  seq_detect_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (bus.in_data),
    .det_rst   (w_det_rst),
    .det_x     (w_det_x),
    .det_y     (w_det_y),
    .res_valid (bus.res_valid),
    .res_ready (bus.res_ready),
    .res_count (bus.res_count),
    .res_mask  (bus.res_mask)
  );

  state_machine u_det (
    .clk (clk),
    .rst (w_det_rst),
    .X   (w_det_x),
    .Y   (w_det_y)
  );

endmodule

// File: rtl/state_machine.sv
// Serial "101" detector, overlapping, with a registered Moore output.
// Y rises the cycle after the bit that completes the pattern.
module state_machine (
  input  logic clk,
  input  logic rst,
  input  logic X,
  output logic Y
);

  typedef enum logic [1:0] {
    S_NONE,
    S_1,
    S_10
  } det_t;

  det_t r_st;
  det_t w_nxt;
  logic r_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= S_NONE;
      r_y  <= 1'b0;
    end else begin
      r_st <= w_nxt;
      r_y  <= (r_st == S_10) && X;
    end
  end

  always_comb begin
    w_nxt = S_NONE;
    unique case (r_st)
      S_NONE:  w_nxt = X ? S_1 : S_NONE;
      S_1:     w_nxt = X ? S_1 : S_10;
      S_10:    w_nxt = X ? S_1 : S_NONE;
      default: w_nxt = S_NONE;
    endcase
  end

  assign Y = r_y;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Streams a word MSB-first into a serial detector and collects its hits.
// Returns a hit count and a per-bit hit mask over a valid/ready result.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             det_rst,
  output logic             det_x,
  input  logic             det_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [WIDTH-1:0] res_mask
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_pidx;
  logic             r_pv;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_mask;
  logic             w_acc;
  logic             w_cap;

  assign in_ready  = (r_state == IDLE) & ~rst;
  assign w_acc     = in_valid & in_ready;
  assign det_rst   = rst | (r_state == CLR);
  assign det_x     = ~rst & (r_state == SHIFT)
                   & r_shreg[WIDTH-1];
  assign res_valid = ~rst & (r_state == DONE);
  assign res_count = r_count;
  assign res_mask  = r_mask;

  // det_y lags det_x by one cycle, so tag it with the prior index
  assign w_cap = r_pv
               & ((r_state == SHIFT) | (r_state == DRAIN));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_next = CLR;
      CLR:     w_next = SHIFT;
      SHIFT:   if (r_idx == '0) w_next = DRAIN;
      DRAIN:   w_next = DONE;
      DONE:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_idx   <= '0;
      r_pidx  <= '0;
      r_pv    <= 1'b0;
      r_count <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_next;
      r_pv    <= (r_state == SHIFT);
      r_pidx  <= r_idx;
      if (w_acc) begin
        r_shreg <= in_data;
        r_count <= '0;
        r_mask  <= '0;
      end
      if (r_state == CLR) begin
        r_idx <= IW'(WIDTH - 1);
      end
      if (r_state == SHIFT) begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        r_idx   <= r_idx - IW'(1);
      end
      if (w_cap && det_y) begin
        r_count         <= r_count + CNT_W'(1);
        r_mask[r_pidx]  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for the controller with a stub detector and for the
// integrated controller plus "101" detector.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       det_rst;
  logic       det_x;
  logic       det_y;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_count;
  logic [7:0] res_mask;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   stub_mode = 0;
  logic r_echo;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .det_rst   (det_rst),
    .det_x     (det_x),
    .det_y     (det_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_mask  (res_mask)
  );

  seq_detect_ctrl_if #(.WIDTH(8)) bus ();

  seq_detect_top #(.WIDTH(8)) u_top (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // stub: 0 echoes last det_x, 1 drives 0, 2 drives 1
  always @(posedge clk) r_echo <= det_x;

  always_comb begin
    det_y = 1'b0;
    if (stub_mode == 0) det_y = r_echo;
    else if (stub_mode == 2) det_y = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " res_valid"}, 32'(res_valid), 32'd1);
  endtask

  task automatic send(input logic [7:0] d,
                      input logic rdy,
                      input string tag);
    res_ready = rdy;
    in_data   = d;
    in_valid  = 1'b1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    wait_res(tag);
  endtask

  task automatic wait_bus(input string tag);
    int n = 0;
    while (!bus.res_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " res_valid"}, 32'(bus.res_valid), 32'd1);
  endtask

  // reference "101" overlapping detector, fresh from reset per word
  function automatic void model(input  logic [7:0] d,
                                output logic [3:0] cnt,
                                output logic [7:0] msk);
    int st = 0;
    cnt = '0;
    msk = '0;
    for (int p = 7; p >= 0; p--) begin
      if (st == 2 && d[p]) begin
        cnt    = cnt + 4'd1;
        msk[p] = 1'b1;
      end
      if (d[p])       st = 1;
      else if (st==1) st = 2;
      else            st = 0;
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] xs;
    logic [7:0] words [2];
    logic [3:0] m_cnt;
    logic [7:0] m_msk;
    logic       seen;
    int         n;

    rst           = 1'b1;
    in_valid      = 1'b0;
    in_data       = '0;
    res_ready     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;

    // 1: reset
    tick();
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst det_rst", 32'(det_rst), 32'd1);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst count", 32'(res_count), 32'd0);
    chk("rst mask", 32'(res_mask), 32'd0);
    chk("rst det_x", 32'(det_x), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle in_ready", 32'(in_ready), 32'd1);
    chk("idle det_rst", 32'(det_rst), 32'd0);
    chk("idle res_valid", 32'(res_valid), 32'd0);

    // 2: echo stub, latency and bit order
    stub_mode = 0;
    res_ready = 1'b1;
    in_data   = 8'b1011_0010;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("clr det_rst", 32'(det_rst), 32'd1);
    chk("clr det_x", 32'(det_x), 32'd0);
    chk("clr in_ready", 32'(in_ready), 32'd0);
    for (int i = 7; i >= 0; i--) begin
      tick();
      xs[i] = det_x;
    end
    chk("x sequence", 32'(xs), 32'h0000_00B2);
    tick();
    chk("E9 res_valid", 32'(res_valid), 32'd0);
    tick();
    chk("E10 res_valid", 32'(res_valid), 32'd1);
    chk("echo count", 32'(res_count), 32'd4);
    chk("echo mask", 32'(res_mask), 32'h0000_00B2);
    tick();
    chk("post res_valid", 32'(res_valid), 32'd0);
    chk("post in_ready", 32'(in_ready), 32'd1);

    // 3: constant stubs
    stub_mode = 1;
    send(8'hFF, 1'b1, "y0");
    chk("y0 count", 32'(res_count), 32'd0);
    chk("y0 mask", 32'(res_mask), 32'd0);
    tick();
    stub_mode = 2;
    send(8'h00, 1'b1, "y1");
    chk("y1 count", 32'(res_count), 32'd8);
    chk("y1 mask", 32'(res_mask), 32'h0000_00FF);
    tick();

    // 4: result backpressure
    stub_mode = 0;
    send(8'h5A, 1'b0, "bp");
    in_data  = 8'hC3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp hold valid", 32'(res_valid), 32'd1);
      chk("bp hold count", 32'(res_count), 32'd4);
      chk("bp hold mask", 32'(res_mask), 32'h0000_005A);
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    chk("bp release valid", 32'(res_valid), 32'd0);
    chk("bp release rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp2 det_rst", 32'(det_rst), 32'd1);
    wait_res("bp2");
    chk("bp2 count", 32'(res_count), 32'd4);
    chk("bp2 mask", 32'(res_mask), 32'h0000_00C3);
    tick();

    // 5: reset after three bits
    in_data  = 8'hE7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid det_rst", 32'(det_rst), 32'd1);
    chk("mid in_ready", 32'(in_ready), 32'd0);
    chk("mid det_x", 32'(det_x), 32'd0);
    tick();
    chk("mid rst valid", 32'(res_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid idle rdy", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | res_valid;
    end
    chk("mid no result", 32'(seen), 32'd0);
    send(8'hE7, 1'b1, "fresh");
    chk("fresh count", 32'(res_count), 32'd6);
    chk("fresh mask", 32'(res_mask), 32'h0000_00E7);
    tick();

    // 6: integrated detector, back-to-back words
    words[0]      = 8'b0111_0100;
    words[1]      = 8'b0000_0000;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.in_data  = words[k];
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 20) begin
        tick();
        n++;
      end
      chk("int in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      if (k == 0) bus.in_data = words[1];
      else        bus.in_valid = 1'b0;
      wait_bus("int");
      model(words[k], m_cnt, m_msk);
      chk("int count", 32'(bus.res_count), 32'(m_cnt));
      chk("int mask", 32'(bus.res_mask), 32'(m_msk));
      if (k == 1) begin
        chk("int zero count", 32'(bus.res_count), 32'd0);
      end
      tick();
    end
    bus.in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
